parallel_serial: RTL and testbench

- Transmit-side serializer for the bus. It sits directly upstream of the serial_parallel deserializer and feeds it.
- Accepts a parallel word plus a per-transfer bit length.
- Shifts the word out MSB-first, one bit per clock, with a valid strobe.
- Signals busy during the transfer and pulses done after the last bit.

---
 rtl/parallel_serial.sv | 179 +++++++++++++++++
 tb/tb_parallel_serial.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_serial.sv
// parallel_serial: MSB-first parallel-to-serial transmitter.
// Loads a PORT_WIDTH word with a per-transfer bit length, streams N bits
// one per clock with a valid strobe, then pulses done for one cycle.
// Optional build macro PS_PARITY_EN appends one even-parity bit after the
// N data bits (the XOR of the transmitted bits).
//
// Handshake: a transfer is accepted on a rising edge where en=1, load=1
// and busy=0 (state IDLE or DONE); load while busy is dropped, never queued.
// dout is meaningful only while dout_v=1. en=0 aborts to IDLE on the next
// edge with all outputs cleared and no done pulse.
module parallel_serial #(
  parameter int PORT_WIDTH = 14,
  parameter int BIT_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [PORT_WIDTH-1:0] din,
  input  logic [BIT_LENGTH-1:0] bit_lngth,
  input  logic                  load,
  input  logic                  en,
  output logic                  dout,
  output logic                  dout_v,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [BIT_LENGTH-1:0] PW_L = BIT_LENGTH'(PORT_WIDTH);

  state_t                state_q, state_d;
  logic [PORT_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_LENGTH-1:0] cnt_q, cnt_d;
  logic                  dout_q, dout_d;
  logic                  dout_v_q, dout_v_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [BIT_LENGTH-1:0] n_eff;
  logic [BIT_LENGTH-1:0] shamt;
  logic [PORT_WIDTH-1:0] aligned;

`ifdef PS_PARITY_EN
  logic                  par_q, par_d;
  logic                  par_phase_q, par_phase_d;
  logic                  par_load;
`endif

  // Clamp length and left-align the word so bit N-1 sits at the MSB.
  always_comb begin
    n_eff   = (bit_lngth == '0 || bit_lngth > PW_L) ? PW_L : bit_lngth;
    shamt   = PW_L - n_eff;
    aligned = din << shamt;
`ifdef PS_PARITY_EN
    par_load = ^(din & ({PORT_WIDTH{1'b1}} >> shamt));
`endif
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dout_v_d = dout_v_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef PS_PARITY_EN
    par_d       = par_q;
    par_phase_d = par_phase_q;
`endif
    if (!en) begin
      state_d  = S_IDLE;
      dout_d   = 1'b0;
      dout_v_d = 1'b0;
      busy_d   = 1'b0;
`ifdef PS_PARITY_EN
      par_phase_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load) begin
            state_d  = S_SHIFT;
            shreg_d  = aligned;
            cnt_d    = n_eff - 1'b1;
            dout_d   = aligned[PORT_WIDTH-1];
            dout_v_d = 1'b1;
            busy_d   = 1'b1;
`ifdef PS_PARITY_EN
            par_d       = par_load;
            par_phase_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
`ifdef PS_PARITY_EN
          if (par_phase_q) begin
            state_d     = S_DONE;
            dout_d      = 1'b0;
            dout_v_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            par_phase_d = 1'b0;
          end else if (cnt_q != '0) begin
            shreg_d = shreg_q << 1;
            dout_d  = shreg_q[PORT_WIDTH-2];
            cnt_d   = cnt_q - 1'b1;
          end else begin
            dout_d      = par_q;
            par_phase_d = 1'b1;
          end
`else
          if (cnt_q != '0) begin
            shreg_d = shreg_q << 1;
            dout_d  = shreg_q[PORT_WIDTH-2];
            cnt_d   = cnt_q - 1'b1;
          end else begin
            state_d  = S_DONE;
            dout_d   = 1'b0;
            dout_v_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
`endif
        end
        default: begin
          state_d  = S_IDLE;
          dout_d   = 1'b0;
          dout_v_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dout_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PS_PARITY_EN
      par_q       <= 1'b0;
      par_phase_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dout_v_q <= dout_v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PS_PARITY_EN
      par_q       <= par_d;
      par_phase_q <= par_phase_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign dout_v    = dout_v_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_parallel_serial.sv
// tb_parallel_serial: table vectors, hand-written corner sequences and a
// randomized loopback receiver for parallel_serial.
module tb_parallel_serial;

  localparam int PW = 14;
  localparam int BL = 4;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [PW-1:0] din = '0;
  logic [BL-1:0] bit_lngth = '0;
  logic          load = 1'b0;
  logic          en = 1'b0;
  logic          dout, dout_v, busy, done;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  parallel_serial #(.PORT_WIDTH(PW), .BIT_LENGTH(BL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .bit_lngth (bit_lngth),
    .load      (load),
    .en        (en),
    .dout      (dout),
    .dout_v    (dout_v),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [PW-1:0] din;
    logic [BL-1:0] len;
    int            exp_n;
    logic          exp_par;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: spec-level length clamp and parity
  function automatic int model_n(input logic [BL-1:0] l);
    return (l == 0 || int'(l) > PW) ? PW : int'(l);
  endfunction

  function automatic logic model_par(input logic [PW-1:0] d, input int n);
    logic p = 1'b0;
    for (int i = 0; i < n; i++) p = p ^ d[i];
    return p;
  endfunction

  // Scoreboard: expected serial bit stream
  task automatic build_exp(input logic [PW-1:0] d, input int n, input logic par);
    exp_q.delete();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PS_PARITY_EN
    exp_q.push_back(par);
`else
    if (par) begin end
`endif
  endtask

  // Driver tasks
  task automatic drive_load(input logic [PW-1:0] d, input logic [BL-1:0] l);
    din       = d;
    bit_lngth = l;
    load      = 1'b1;
  endtask

  // Called at the negedge after the accepting edge; returns at the done cycle.
  task automatic check_stream(input string tag, input int inject);
    int tot = exp_q.size();
    for (int k = 0; k < tot; k++) begin
      if (k == inject) begin
        din       = ~din;
        bit_lngth = 4'd2;
        load      = 1'b1;
      end else begin
        load = 1'b0;
      end
      chk({tag, " dout_v"}, dout_v, 1);
      chk({tag, " dout"}, dout, exp_q.pop_front());
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done_early"}, done, 0);
      @(negedge clk);
    end
    load = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " dout_v_end"}, dout_v, 0);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " dout_end"}, dout, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_dout_v"}, dout_v, 0);
  endtask

  initial begin
    vecs[0] = '{din: 14'h2A5B, len: 4'd14, exp_n: 14, exp_par: 1'b0};
    vecs[1] = '{din: 14'h0005, len: 4'd3,  exp_n: 3,  exp_par: 1'b0};
    vecs[2] = '{din: 14'h0005, len: 4'd0,  exp_n: 14, exp_par: 1'b0};
    vecs[3] = '{din: 14'h1234, len: 4'd15, exp_n: 14, exp_par: 1'b1};
    vecs[4] = '{din: 14'h0007, len: 4'd3,  exp_n: 3,  exp_par: 1'b1};
    vecs[5] = '{din: 14'h0003, len: 4'd3,  exp_n: 3,  exp_par: 1'b0};
    vecs[6] = '{din: 14'h3FFF, len: 4'd1,  exp_n: 1,  exp_par: 1'b1};
    vecs[7] = '{din: 14'h2000, len: 4'd14, exp_n: 14, exp_par: 1'b1};
    vecs[8] = '{din: 14'h2000, len: 4'd13, exp_n: 13, exp_par: 1'b0};
    vecs[9] = '{din: 14'h155A, len: 4'd9,  exp_n: 9,  exp_par: 1'b1};

    // Reset state
    #12;
    chk("rst dout", dout, 0);
    chk("rst dout_v", dout_v, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst state", state_dbg, 0);
    @(negedge clk);
    rstn = 1'b1;
    en   = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      drive_load(vecs[v].din, vecs[v].len);
      @(negedge clk);
      build_exp(vecs[v].din, vecs[v].exp_n, vecs[v].exp_par);
      check_stream($sformatf("vec%0d", v), -1);
      @(negedge clk);
      check_idle($sformatf("vec%0d", v));
    end

    // Load while busy is ignored, then load during done cycle chains
    drive_load(14'h2A5B, 4'd14);
    @(negedge clk);
    build_exp(14'h2A5B, 14, 1'b0);
    check_stream("ign", 4);
    drive_load(14'h0005, 4'd3);
    @(negedge clk);
    build_exp(14'h0005, 3, 1'b0);
    check_stream("b2b", -1);
    @(negedge clk);
    check_idle("b2b");

    // Abort via en after 4 bits of a 10-bit transfer
    drive_load(14'h035A, 4'd10);
    @(negedge clk);
    load = 1'b0;
    build_exp(14'h035A, 10, model_par(14'h035A, 10));
    for (int k = 0; k < 4; k++) begin
      chk("abt dout_v", dout_v, 1);
      chk("abt dout", dout, exp_q.pop_front());
      if (k == 3) en = 1'b0;
      @(negedge clk);
    end
    chk("abt dout_off", dout, 0);
    check_idle("abt");
    chk("abt state", state_dbg, 0);
    load = 1'b1;
    @(negedge clk);
    check_idle("abt_enlow_load");
    en = 1'b1;
    drive_load(14'h0ABC, 4'd12);
    @(negedge clk);
    build_exp(14'h0ABC, 12, model_par(14'h0ABC, 12));
    check_stream("restart", -1);
    @(negedge clk);
    check_idle("restart");

    // Asynchronous reset mid-transfer
    drive_load(14'h3FFF, 4'd14);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("arst pre dout", dout, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst dout", dout, 0);
    chk("arst dout_v", dout_v, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("arst_after");

    // Randomized loopback receiver
    for (int t = 0; t < 20; t++) begin
      logic [PW-1:0] d;
      logic [BL-1:0] l;
      logic [15:0]   rx;
      int            n, got;
      logic          seen_done, p;
      logic [15:0]   mask;
      d = PW'($urandom_range(0, 16383));
      l = BL'($urandom_range(0, 15));
      n = model_n(l);
      p = model_par(d, n);
      mask = 16'((32'd1 << n) - 1);
      drive_load(d, l);
      @(negedge clk);
      load = 1'b0;
      rx = '0;
      got = 0;
      seen_done = 1'b0;
      for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
        if (dout_v) begin
          rx = {rx[14:0], dout};
          got++;
        end
        if (done) seen_done = 1'b1;
        else @(negedge clk);
      end
      chk("lb done_seen", seen_done, 1);
`ifdef PS_PARITY_EN
      chk("lb count", got, n + 1);
      chk("lb parity", rx[0], p);
      chk("lb word", (rx >> 1) & mask, 16'(d) & mask);
`else
      chk("lb count", got, n);
      chk("lb word", rx & mask, 16'(d) & mask);
      if (p) begin end
`endif
      @(negedge clk);
      check_idle("lb");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
